// File: rtl/ahb_seq_pkg.sv
// Shared types and constants for the AHB frame sequencer.
package ahb_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARB,
    RD_REQ,
    RD_WAIT,
    WR_REQ,
    WR_WAIT,
    DONE
  } seq_state_t;

  typedef enum logic {
    GRANT_READ,
    GRANT_WRITE
  } grant_t;

  localparam int WORD_BYTES_LOG2 = 2;

endpackage

// File: rtl/seq_rr_arbiter.sv
// Two-requester round-robin arbiter; when both streams are ready the one
// that did not win last time gets the grant.
module seq_rr_arbiter
  import ahb_seq_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic rd_ok,
  input  logic wr_ok,
  input  logic advance,
  output logic grant_rd,
  output logic grant_wr
);

  grant_t last_grant;

  always_comb begin
    grant_rd = 1'b0;
    grant_wr = 1'b0;
    if (rd_ok && wr_ok) begin
      if (last_grant == GRANT_WRITE) grant_rd = 1'b1;
      else                           grant_wr = 1'b1;
    end else begin
      grant_rd = rd_ok;
      grant_wr = wr_ok;
    end
  end

  // Starting from WRITE hands the first contested grant to the read stream.
  always_ff @(posedge clk) begin
    if (rst)                      last_grant <= GRANT_WRITE;
    else if (advance && grant_rd) last_grant <= GRANT_READ;
    else if (advance && grant_wr) last_grant <= GRANT_WRITE;
  end

endmodule

// File: rtl/ahb_frame_sequencer.sv
// Schedules AHB reads of source pixels and writes of greyscale results,
// throttling reads so no more than BUF_DEPTH words are in flight.
module ahb_frame_sequencer
  import ahb_seq_pkg::*;
#(
  parameter int BUF_DEPTH = 4,
  parameter int CNT_W     = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [31:0]      src_base,
  input  logic [31:0]      dst_base,
  input  logic [CNT_W-1:0] num_words,
  input  logic             read_complete,
  input  logic             write_complete,
  input  logic             wr_data_avail,
  output logic             re,
  output logic             we,
  output logic [31:0]      mcu_raddr,
  output logic [31:0]      mcu_waddr,
  output logic             rd_word_valid,
  output logic             wr_pop,
  output logic             busy,
  output logic             done
);

  seq_state_t       state, state_nxt;
  logic [31:0]      src_lat, dst_lat;
  logic [CNT_W-1:0] num_lat, rd_idx, wr_idx;
  logic [3:0]       in_flight;
  logic             rd_ok, wr_ok, advance, grant_rd, grant_wr;

  assign rd_ok   = (rd_idx < num_lat) && (in_flight < 4'(BUF_DEPTH));
  assign wr_ok   = wr_data_avail && (wr_idx < rd_idx);
  assign advance = (state == ARB) && (wr_idx != num_lat);

  seq_rr_arbiter u_arb (
    .clk      (clk),
    .rst      (rst),
    .rd_ok    (rd_ok),
    .wr_ok    (wr_ok),
    .advance  (advance),
    .grant_rd (grant_rd),
    .grant_wr (grant_wr)
  );

  // Addresses are pure functions of registered state, so they hold steady
  // from the request through its completion.
  assign mcu_raddr = src_lat + (32'(rd_idx) << WORD_BYTES_LOG2);
  assign mcu_waddr = dst_lat + (32'(wr_idx) << WORD_BYTES_LOG2);

  always_comb begin
    state_nxt = state;
    re        = 1'b0;
    we        = 1'b0;
    busy      = (state != IDLE);
    done      = 1'b0;
    case (state)
      IDLE:    if (start) state_nxt = ARB;
      ARB: begin
        if (wr_idx == num_lat) state_nxt = DONE;
        else if (grant_rd)     state_nxt = RD_REQ;
        else if (grant_wr)     state_nxt = WR_REQ;
      end
      RD_REQ: begin
        re        = 1'b1;
        state_nxt = RD_WAIT;
      end
      RD_WAIT: if (read_complete) state_nxt = ARB;
      WR_REQ: begin
        we        = 1'b1;
        state_nxt = WR_WAIT;
      end
      WR_WAIT: if (write_complete) state_nxt = ARB;
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      src_lat       <= '0;
      dst_lat       <= '0;
      num_lat       <= '0;
      rd_idx        <= '0;
      wr_idx        <= '0;
      in_flight     <= '0;
      rd_word_valid <= 1'b0;
      wr_pop        <= 1'b0;
    end else begin
      state         <= state_nxt;
      rd_word_valid <= (state == RD_WAIT) && read_complete;
      wr_pop        <= (state == WR_WAIT) && write_complete;
      case (state)
        IDLE: if (start) begin
          src_lat   <= src_base;
          dst_lat   <= dst_base;
          num_lat   <= num_words;
          rd_idx    <= '0;
          wr_idx    <= '0;
          in_flight <= '0;
        end
        RD_REQ:  in_flight <= in_flight + 4'd1;
        RD_WAIT: if (read_complete) rd_idx <= rd_idx + 1'b1;
        WR_WAIT: if (write_complete) begin
          wr_idx    <= wr_idx + 1'b1;
          in_flight <= in_flight - 4'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_frame_sequencer.sv
// Directed self-checking bench for ahb_frame_sequencer with a hand-driven
// AHB master that answers each request after a one-cycle wait.
module tb_ahb_frame_sequencer;
  import ahb_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] src_base = '0;
  logic [31:0] dst_base = '0;
  logic [19:0] num_words = '0;
  logic        read_complete = 1'b0;
  logic        write_complete = 1'b0;
  logic        wr_data_avail = 1'b0;
  logic        re, we, rd_word_valid, wr_pop, busy, done;
  logic [31:0] mcu_raddr, mcu_waddr;

  int checks = 0;
  int errors = 0;

  ahb_frame_sequencer #(.BUF_DEPTH(4), .CNT_W(20)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .src_base       (src_base),
    .dst_base       (dst_base),
    .num_words      (num_words),
    .read_complete  (read_complete),
    .write_complete (write_complete),
    .wr_data_avail  (wr_data_avail),
    .re             (re),
    .we             (we),
    .mcu_raddr      (mcu_raddr),
    .mcu_waddr      (mcu_waddr),
    .rd_word_valid  (rd_word_valid),
    .wr_pop         (wr_pop),
    .busy           (busy),
    .done           (done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] src, input logic [31:0] dst, input logic [19:0] n);
    src_base  = src;
    dst_base  = dst;
    num_words = n;
    start     = 1'b1;
    step();
    start     = 1'b0;
  endtask

  // Waits (bounded) for the next request and checks its kind and address.
  task automatic expectReq(input logic is_rd, input logic [31:0] addr, input string tag);
    int n = 0;
    while (!(re || we) && n < 40) begin
      step();
      n++;
    end
    checkOutput({tag, "_re"}, 32'(re), 32'(is_rd));
    checkOutput({tag, "_we"}, 32'(we), 32'(!is_rd));
    checkOutput({tag, "_addr"}, is_rd ? mcu_raddr : mcu_waddr, addr);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd1);
  endtask

  // Called in the REQ cycle: address phase, data phase, then completion.
  task automatic serveReq(input logic is_rd, input logic [31:0] addr, input string tag);
    step();
    step();
    checkOutput({tag, "_hold"}, is_rd ? mcu_raddr : mcu_waddr, addr);
    if (is_rd) read_complete = 1'b1;
    else       write_complete = 1'b1;
    step();
    read_complete  = 1'b0;
    write_complete = 1'b0;
    checkOutput({tag, "_pulse"}, 32'(is_rd ? rd_word_valid : wr_pop), 32'd1);
  endtask

  task automatic xfer(input logic is_rd, input logic [31:0] addr, input string tag);
    expectReq(is_rd, addr, tag);
    serveReq(is_rd, addr, tag);
  endtask

  initial begin
    logic seen;

    step();
    step();
    checkOutput("rst_ctrl", {26'd0, re, we, rd_word_valid, wr_pop, busy, done}, 32'd0);
    checkOutput("rst_raddr", mcu_raddr, 32'd0);
    checkOutput("rst_waddr", mcu_waddr, 32'd0);
    rst = 1'b0;
    step();

    // Reset while a read is outstanding aborts the frame.
    applyStimulus(32'h1000, 32'h8000, 20'd8);
    expectReq(1'b1, 32'h1000, "abort_r0");
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checkOutput("abort_ctrl", {26'd0, re, we, rd_word_valid, wr_pop, busy, done}, 32'd0);
    checkOutput("abort_raddr", mcu_raddr, 32'd0);
    checkOutput("abort_state", 32'(dut.state), 32'(IDLE));
    read_complete = 1'b1;
    step();
    read_complete = 1'b0;
    checkOutput("abort_late_rc", 32'(rd_word_valid), 32'd0);
    step();

    // Three-word frame with results always ready: strict read/write alternation.
    wr_data_avail = 1'b1;
    applyStimulus(32'h1000, 32'h8000, 20'd3);
    checkOutput("f3_busy_arb", 32'(busy), 32'd1);
    xfer(1'b1, 32'h1000, "f3_r0");
    xfer(1'b0, 32'h8000, "f3_w0");
    xfer(1'b1, 32'h1004, "f3_r1");
    xfer(1'b0, 32'h8004, "f3_w1");
    xfer(1'b1, 32'h1008, "f3_r2");
    xfer(1'b0, 32'h8008, "f3_w2");
    step();
    checkOutput("f3_done", {30'd0, busy, done}, 32'd3);
    step();
    checkOutput("f3_idle", {30'd0, busy, done}, 32'd0);
    wr_data_avail = 1'b0;

    // Credit throttle: four reads, then parked until a write frees a slot.
    applyStimulus(32'h1000, 32'h8000, 20'd10);
    xfer(1'b1, 32'h1000, "cr_r0");
    xfer(1'b1, 32'h1004, "cr_r1");
    xfer(1'b1, 32'h1008, "cr_r2");
    xfer(1'b1, 32'h100C, "cr_r3");
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      seen = seen | re | we;
      step();
    end
    checkOutput("cr_parked_req", 32'(seen), 32'd0);
    checkOutput("cr_parked_state", 32'(dut.state), 32'(ARB));
    wr_data_avail = 1'b1;
    xfer(1'b0, 32'h8000, "cr_w0");
    expectReq(1'b1, 32'h1010, "cr_r4");
    wr_data_avail = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();

    // Empty frame: done two cycles after start, no traffic.
    applyStimulus(32'h1000, 32'h8000, 20'd0);
    checkOutput("z_arb", {28'd0, re, we, wr_pop, done}, 32'd0);
    step();
    checkOutput("z_done", {28'd0, re, we, wr_pop, done}, 32'd1);
    step();
    checkOutput("z_idle", {28'd0, re, we, busy, done}, 32'd0);

    // Spurious write_complete and start while busy are ignored.
    applyStimulus(32'h2000, 32'h9000, 20'd2);
    expectReq(1'b1, 32'h2000, "sp_r0");
    step();
    write_complete = 1'b1;
    start          = 1'b1;
    src_base       = 32'h5555_0000;
    dst_base       = 32'h6666_0000;
    num_words      = 20'd7;
    step();
    write_complete = 1'b0;
    start          = 1'b0;
    step();
    checkOutput("sp_wr_pop", 32'(wr_pop), 32'd0);
    checkOutput("sp_wr_idx", 32'(dut.wr_idx), 32'd0);
    checkOutput("sp_raddr", mcu_raddr, 32'h2000);
    checkOutput("sp_waddr", mcu_waddr, 32'h9000);
    read_complete = 1'b1;
    step();
    read_complete = 1'b0;
    checkOutput("sp_r0_pulse", 32'(rd_word_valid), 32'd1);
    wr_data_avail = 1'b1;
    xfer(1'b0, 32'h9000, "sp_w0");
    xfer(1'b1, 32'h2004, "sp_r1");
    xfer(1'b0, 32'h9004, "sp_w1");
    step();
    checkOutput("sp_done", 32'(done), 32'd1);
    step();

    // Source address wraps past 2^32.
    applyStimulus(32'hFFFF_FFF8, 32'h0000_0100, 20'd3);
    xfer(1'b1, 32'hFFFF_FFF8, "wrap_r0");
    xfer(1'b0, 32'h0000_0100, "wrap_w0");
    xfer(1'b1, 32'hFFFF_FFFC, "wrap_r1");
    xfer(1'b0, 32'h0000_0104, "wrap_w1");
    xfer(1'b1, 32'h0000_0000, "wrap_r2");
    xfer(1'b0, 32'h0000_0108, "wrap_w2");
    step();
    checkOutput("wrap_done", 32'(done), 32'd1);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ahb_frame_sequencer.md
Name: ahb_frame_sequencer

Overview:
- Schedules the single-master AHB transfer block between two requesters:
  - a read stream that fetches source pixel words from `src_base`;
  - a write stream that stores processed greyscale words to `dst_base`.
- Generates `re`/`we` plus `mcu_raddr`/`mcu_waddr`, and consumes `read_complete`/`write_complete`.
- Arbitrates the two streams fairly and throttles reads with an in-flight credit count so the processing buffer cannot overflow.
- Sits between the top-level MCU control and the AHB master, beside the greyscale processing buffer.

Parameters:
- BUF_DEPTH, 4, maximum words read but not yet written back (in-flight credit limit), 1..15.
- CNT_W, 20, width of word counters (supports frames up to 2^20-1 words).

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- start  in  1  one-cycle pulse; begins a frame when idle
- src_base  in  32  source byte base address, sampled on accepted start
- dst_base  in  32  destination byte base address, sampled on accepted start
- num_words  in  CNT_W  words in frame, sampled on accepted start
- read_complete  in  1  AHB master read finished; read data valid this cycle
- write_complete  in  1  AHB master write finished
- wr_data_avail  in  1  processing buffer holds a result word ready to write
- re  out  1  read request pulse to AHB master
- we  out  1  write request pulse to AHB master
- mcu_raddr  out  32  read byte address
- mcu_waddr  out  32  write byte address
- rd_word_valid  out  1  registered pulse, one cycle after an accepted read_complete
- wr_pop  out  1  registered pulse, one cycle after an accepted write_complete; buffer drops its head word
- busy  out  1  high from accepted start until the done cycle inclusive
- done  out  1  one-cycle pulse at frame end

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high. Names are `clk` and `rst`.
- Reset values:
  - All outputs are 0.
  - state=IDLE; rd_idx=wr_idx=in_flight=0; last_grant=WRITE, so the first contested grant goes to read.
  - Reset asserted mid-transfer aborts at the next edge. No completion is counted afterwards.
- States:
  - IDLE: start=1 latches bases/num_words and zeroes counters → ARB. start while not IDLE is ignored.
  - ARB:
    - If wr_idx==num_lat → DONE.
    - rd_ok = (rd_idx<num_lat) && (in_flight<BUF_DEPTH).
    - wr_ok = wr_data_avail && (wr_idx<rd_idx).
    - Both ok: grant the opposite of last_grant. One ok: grant it. Neither: stay in ARB.
    - A read grant → RD_REQ; a write grant → WR_REQ. Update last_grant.
  - RD_REQ: `re`=1 for exactly this cycle; in_flight+1 → RD_WAIT.
  - RD_WAIT: on read_complete, rd_idx+1 and rd_word_valid next cycle → ARB.
  - WR_REQ: `we`=1 for exactly this cycle → WR_WAIT.
  - WR_WAIT: on write_complete, wr_idx+1, in_flight-1, wr_pop next cycle → ARB.
  - DONE: done=1 for one cycle → IDLE. busy drops the following cycle.
- Addresses (Moore outputs):
  - mcu_raddr = src_lat + (rd_idx<<2); mcu_waddr = dst_lat + (wr_idx<<2).
  - 32-bit wrap-around is allowed with no error.
  - Addresses stay stable from the REQ state through the matching completion. The AHB master samples the address one cycle after re/we.
- Completion handling:
  - read_complete outside RD_WAIT and write_complete outside WR_WAIT are ignored, with no counter change.
  - At most one transfer is outstanding; re and we are never high together.
  - Minimum read turnaround: ARB, REQ, AHB address, data (≥1), complete. The next request is no earlier than the cycle after completion.
- num_words=0: start → ARB → DONE, with no re/we.

Decomposition:
- Shared package ahb_seq_pkg holds:
  - state enum seq_state_t {IDLE, ARB, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, DONE};
  - grant enum {GRANT_READ, GRANT_WRITE};
  - constant WORD_BYTES_LOG2=2.
- One natural sub-module: seq_rr_arbiter, a 2-requester round-robin holding last_grant. Its inputs are rd_ok, wr_ok and an advance strobe; its outputs are grant_rd and grant_wr.
- Counters and the FSM stay in the top module.

Test Plan:
- rst=1 mid-RD_WAIT with num_words=8 → next cycle all outputs 0 and state IDLE; a later read_complete is ignored (no rd_word_valid).
- start, src_base=0x1000, dst_base=0x8000, num_words=3, wr_data_avail held 1, AHB model 1-wait → required order:
  - R0x1000, W0x8000, R0x1004, W0x8004, R0x1008, W0x8008;
  - then done one cycle, with busy high throughout.
- BUF_DEPTH=4, num_words=10, wr_data_avail=0 → exactly 4 re pulses (0x1000..0x100C), then no re and sequencer parked in ARB. Raising wr_data_avail → we at 0x8000, then the next re at 0x1010.
- num_words=0 → done pulses 2 cycles after start; re, we, wr_pop never asserted.
- Spurious write_complete during RD_WAIT, and a start pulse while busy → no wr_pop, wr_idx unchanged, base addresses unchanged.
- src_base=0xFFFFFFF8, num_words=3 → read addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
